ram_stream_reader: RTL

- Read-side controller for the team's dual-port RAM model, which has a 2-cycle registered read path and raddr sampled on posedge.
- On a start pulse it reads len consecutive words from base_addr and emits them as a valid/ready stream, honouring downstream backpressure.
- It sits between the on-chip buffers and the Avalon write-back / compute stream consumers.
- A credit-limited issue path plus an internal FIFO absorbs the fixed read latency without dropping words.

---
 rtl/cnn_mem_pkg.sv | 37 +++
 rtl/sync_fifo_fwft.sv | 78 +++++++
 rtl/ram_stream_reader.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/cnn_mem_pkg.sv
// -----------------------------------------------------------------------------
// cnn_mem_pkg
// Shared types and helpers for the on-chip memory access blocks.
//   state_t         reader FSM states
//   rd_tag_t        per-read tag carried alongside the RAM read latency
//   RD_LAT_DEFAULT  read latency of the team's dual-port RAM model
//   clog2()         constant ceil(log2) used for pointer and count widths
// -----------------------------------------------------------------------------
package cnn_mem_pkg;

   localparam int RD_LAT_DEFAULT = 2;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   // vld marks a read that must be captured; last marks the final read of a request.
   typedef struct packed {
      logic vld;
      logic last;
   } rd_tag_t;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// -----------------------------------------------------------------------------
// sync_fifo_fwft
// Synchronous first-word-fall-through FIFO. The head entry is visible on dout
// whenever empty==0; pop consumes it. DEPTH must be a power of two >= 2.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   push, din    write request and data (ignored when full unless popping)
//   pop          consume the head entry (ignored when empty)
//   dout         head entry
//   empty, full  occupancy flags
//   count        number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module sync_fifo_fwft
   import cnn_mem_pkg::*;
#(
   parameter int DW    = 33,
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic                          pop,
   input  logic [DW-1:0]                 din,
   output logic [DW-1:0]                 dout,
   output logic                          empty,
   output logic                          full,
   output logic [clog2(DEPTH+1)-1:0]     count
);

   localparam int PW = clog2(DEPTH);
   localparam int CW = clog2(DEPTH + 1);

   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_FULL);
   assign do_pop  = pop & ~empty;
   // A push into a full FIFO is only accepted when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // NOTE: storage has no reset; empty/count gate its use, so only the pointers need one.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ram_stream_reader.sv
// -----------------------------------------------------------------------------
// ram_stream_reader
// Reads len consecutive words from a RAM with a fixed registered read latency
// and emits them as a valid/ready stream. Reads are issued only while the
// output buffer has room for every outstanding beat, so backpressure never
// drops a word.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   start                 request pulse (ignored while busy)
//   base_addr, len        first address and word count, sampled with start
//   raddr                 registered RAM read address
//   rdata                 RAM read data, valid RD_LAT cycles after raddr
//   out_data, out_valid,
//   out_ready, out_last   output stream; out_last marks the final word
//   busy                  request in progress
//   done                  one-cycle pulse after the final word is accepted
// -----------------------------------------------------------------------------
module ram_stream_reader
   import cnn_mem_pkg::*;
#(
   parameter int AW         = 12,
   parameter int DW         = 32,
   parameter int RD_LAT     = RD_LAT_DEFAULT,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [AW:0]   len,
   output logic [AW-1:0] raddr,
   input  logic [DW-1:0] rdata,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_last,
   output logic          busy,
   output logic          done
);

   localparam int CW = clog2(FIFO_DEPTH + 1);

   localparam logic [AW-1:0] ADDR_ONE = AW'(1);
   localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);

   state_t          state;
   logic [AW-1:0]   addr;
   logic [AW:0]     rem_cnt;

   // iss is the tag for the read whose raddr is on the bus this cycle;
   // lat_sr carries it through the RAM latency so the last stage lines up with rdata.
   rd_tag_t         iss;
   rd_tag_t         lat_sr [RD_LAT];

   logic            issue_now;
   logic            issue_last;
   logic [AW-1:0]   issue_addr;
   logic            credit_ok;
   int              inflight;
   int              occupancy;

   logic            pop;
   logic [DW:0]     fifo_dout;
   logic            fifo_empty;
   logic            fifo_full;
   logic [CW-1:0]   fifo_count;

   assign out_valid = ~fifo_empty;
   assign out_data  = fifo_empty ? '0 : fifo_dout[DW-1:0];
   assign out_last  = ~fifo_empty & fifo_dout[DW];
   assign pop       = out_valid & out_ready;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      inflight   = 0;
      occupancy  = 0;
      credit_ok  = 1'b0;
      issue_now  = 1'b0;
      issue_last = 1'b0;
      issue_addr = addr;

      // Every outstanding read, including the beat landing this cycle, needs a slot;
      // the head leaving this cycle frees one, which keeps 1 word/cycle at DEPTH=RD_LAT+2.
      if (iss.vld) begin
         inflight++;
      end
      for (int i = 0; i < RD_LAT; i++) begin
         if (lat_sr[i].vld) begin
            inflight++;
         end
      end
      occupancy = int'(fifo_count) - (pop ? 1 : 0) + inflight;
      credit_ok = (occupancy < FIFO_DEPTH);

      case (state)
         IDLE: begin
            // The buffer is empty and nothing is in flight when idle, so the
            // first read goes out on the start edge itself.
            if (start && (len != '0)) begin
               issue_now  = 1'b1;
               issue_addr = base_addr;
               issue_last = (len == LEN_ONE);
            end
         end
         RUN: begin
            if (credit_ok) begin
               issue_now  = 1'b1;
               issue_last = (rem_cnt == LEN_ONE);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         addr    <= '0;
         rem_cnt <= '0;
         raddr   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (issue_now) begin
            raddr <= issue_addr;
            addr  <= issue_addr + ADDR_ONE;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  if (len == '0) begin
                     done <= 1'b1;
                  end else begin
                     rem_cnt <= len - LEN_ONE;
                     busy    <= 1'b1;
                     state   <= (len == LEN_ONE) ? DRAIN : RUN;
                  end
               end
            end
            RUN: begin
               if (issue_now) begin
                  rem_cnt <= rem_cnt - LEN_ONE;
                  if (issue_last) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (pop && out_last) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         iss <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            lat_sr[i] <= '0;
         end
      end else begin
         iss.vld   <= issue_now;
         iss.last  <= issue_last;
         lat_sr[0] <= iss;
         for (int i = 1; i < RD_LAT; i++) begin
            lat_sr[i] <= lat_sr[i-1];
         end
      end
   end

   sync_fifo_fwft #(
      .DW    (DW + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (lat_sr[RD_LAT-1].vld),
      .pop   (pop),
      .din   ({lat_sr[RD_LAT-1].last, rdata}),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   // The credit check must leave room for every beat that returns from the RAM.
   beat_room_chk: assert property (@(posedge clk) disable iff (!rst)
      lat_sr[RD_LAT-1].vld |-> (!fifo_full || pop))
      else $error("ram_stream_reader: read beat arrived at a full output buffer");

endmodule
